serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares one fulladder cell (ports a, b, c, sum, cout) across all bit positions of an N-bit add. It accepts two operands and a carry-in over a valid/ready handshake. It then sequences the fulladder one bit per clock, LSB first, with the carry held in a flip-flop. It returns the N-bit sum and carry-out over a second valid/ready handshake. The fulladder is instantiated inside this block. It sits between lab operand sources (switches/bench) and result sinks (display/checker).

---
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one shared full-adder cell walks the operands LSB first,
// with operands and result exchanged over valid/ready handshakes.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [WIDTH-1:0] sum_sr_reg, sum_sr_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             fa_sum, fa_cout;

    fulladder u_fa (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .c    (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            sum_sr_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_sr_reg   <= a_sr_next;
            b_sr_reg   <= b_sr_next;
            sum_sr_reg <= sum_sr_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_sr_next   = a_sr_reg;
        b_sr_next   = b_sr_reg;
        sum_sr_next = sum_sr_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_sr_next   = a_in;
                    b_sr_next   = b_in;
                    carry_next  = cin;
                    sum_sr_next = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                // New sum bit enters at the MSB so the LSB lands in place after WIDTH shifts.
                sum_sr_next            = sum_sr_reg >> 1;
                sum_sr_next[WIDTH-1]   = fa_sum;
                a_sr_next              = a_sr_reg >> 1;
                b_sr_next              = b_sr_reg >> 1;
                carry_next             = fa_cout;
                cnt_next               = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is exposed only while DONE so consumers never see a half-built sum.
    assign in_ready  = reset_n && (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum_out   = out_valid ? sum_sr_reg : '0;
    assign cout_out  = out_valid & carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized bench for serial_add_ctrl at WIDTH=8 and WIDTH=1,
// checked against plain integer addition.

module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a_in      (a8),
        .b_in      (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum_out   (sum8),
        .cout_out  (cout8),
        .busy      (busy8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_in      (a1),
        .b_in      (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum_out   (sum1),
        .cout_out  (cout1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
        logic [8:0] ref_v;
        int n;
        int busy_n;
        ref_v = 9'(a) + 9'(b) + 9'(c);
        check("idle_ready8", in_ready8, 1);
        check("idle_busy8", busy8, 0);
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        // Operands change right after the accept edge; the result must not care.
        in_valid8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check("run_sum_zero8", sum8, 0);
        busy_n = busy8 ? 1 : 0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            tick();
            n++;
            if (busy8) busy_n++;
        end
        check("latency8", n, 8);
        for (int h = 0; h < hold; h++) begin
            in_valid8 = ~in_valid8;
            a8 = 8'($urandom);
            tick();
            if (busy8) busy_n++;
            check("hold_valid8", out_valid8, 1);
            check("hold_sum8", sum8, 32'(ref_v[7:0]));
            check("hold_ready8", in_ready8, 0);
        end
        check("sum8", sum8, 32'(ref_v[7:0]));
        check("cout8", cout8, 32'(ref_v[8]));
        $display("op w8 a=%02h b=%02h cin=%0d hold=%0d sum=%02h cout=%0d lat=%0d",
                 a, b, c, hold, sum8, cout8, n);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        check("busy_cycles8", busy_n, 32'(9 + hold));
        check("post_ready8", in_ready8, 1);
        check("post_valid8", out_valid8, 0);
        check("post_sum8", sum8, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        logic [1:0] ref_v;
        int n;
        ref_v = 2'(a) + 2'(b) + 2'(c);
        a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1; out_ready1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 10) begin
            tick();
            n++;
        end
        check("latency1", n, 1);
        check("result1", {cout1, sum1}, 32'(ref_v));
        $display("op w1 a=%0d b=%0d cin=%0d -> cout,sum=%0d%0d", a, b, c, cout1, sum1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("post_ready1", in_ready1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        #2;
        check("rst_ready8", in_ready8, 0);
        check("rst_valid8", out_valid8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_ready1", in_ready1, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        check("rel_ready8", in_ready8, 1);

        op8(8'h00, 8'h00, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'hA5, 8'h5A, 1'b1, 0);
        op8(8'h7F, 8'h01, 1'b0, 0);
        op8(8'h12, 8'h34, 1'b0, 5);

        // Abort an operation three RUN edges in.
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (3) tick();
        check("midrun_busy8", busy8, 1);
        reset_n = 1'b0;
        #1;
        check("abort_valid8", out_valid8, 0);
        check("abort_busy8", busy8, 0);
        check("abort_ready8", in_ready8, 0);
        check("abort_cout8", cout8, 0);
        #3;
        reset_n = 1'b1;
        tick();
        check("abort_rel_ready8", in_ready8, 1);
        op8(8'h01, 8'h01, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 8; k++) begin
            op1(k[2], k[1], k[0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
